// File: rtl/rtu_rq_extractor.sv
// rtu_rq_extractor: passive snooper on one port's WR fabric stream.
// Parses each frame's Ethernet header and issues one RTU lookup request.
module rtu_rq_extractor #(
    parameter int g_port_index = 0,
    parameter int g_port_width = 5,
    parameter int g_cnt_width  = 16
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_n_i,
    input  logic                    snk_cyc_i,
    input  logic                    snk_stb_i,
    input  logic                    snk_stall_i,
    input  logic [1:0]              snk_adr_i,
    input  logic [15:0]             snk_dat_i,
    input  logic [11:0]             pvid_i,
    input  logic [2:0]              pprio_i,
    output logic                    rq_valid_o,
    input  logic                    rq_ack_i,
    output logic [47:0]             rq_dmac_o,
    output logic [47:0]             rq_smac_o,
    output logic [11:0]             rq_vid_o,
    output logic [2:0]              rq_prio_o,
    output logic                    rq_has_prio_o,
    output logic [g_port_width-1:0] rq_port_o,
    output logic [g_cnt_width-1:0]  drop_cnt_o,
    output logic [g_cnt_width-1:0]  abort_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_ISSUE,
        S_WAIT_END
    } state_t;

    localparam logic [15:0] c_tpid_8021q = 16'h8100;
    localparam logic [g_cnt_width-1:0] c_cnt_max = '1;

    state_t      state;
    logic        cyc_d;
    logic [2:0]  wcnt;
    logic [47:0] dmac_q;
    logic [47:0] smac_q;
    logic [15:0] tci_q;
    logic        tagged_q;

    logic accept;
    logic data_word;
    logic cyc_rise;
    logic hdr_abort;
    logic issue_load;
    logic issue_drop;

    assign accept     = snk_cyc_i & snk_stb_i & ~snk_stall_i;
    assign data_word  = accept & (snk_adr_i == 2'd0);
    assign cyc_rise   = snk_cyc_i & ~cyc_d;
    assign hdr_abort  = (state == S_HDR) & ~snk_cyc_i;
    assign issue_load = (state == S_ISSUE) & (~rq_valid_o | rq_ack_i);
    assign issue_drop = (state == S_ISSUE) & rq_valid_o & ~rq_ack_i;

    assign rq_port_o = g_port_width'(g_port_index);

    // Resets high so a frame already in flight at reset release is not
    // mistaken for a new frame start.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) cyc_d <= 1'b1;
        else          cyc_d <= snk_cyc_i;
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= S_IDLE;
            wcnt     <= 3'd0;
            dmac_q   <= 48'd0;
            smac_q   <= 48'd0;
            tci_q    <= 16'd0;
            tagged_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cyc_rise) begin
                        state <= S_HDR;
                        wcnt  <= 3'd0;
                    end
                end
                S_HDR: begin
                    if (!snk_cyc_i) begin
                        state <= S_IDLE;
                    end else if (data_word) begin
                        wcnt <= wcnt + 3'd1;
                        case (wcnt)
                            3'd0: dmac_q[47:32] <= snk_dat_i;
                            3'd1: dmac_q[31:16] <= snk_dat_i;
                            3'd2: dmac_q[15:0]  <= snk_dat_i;
                            3'd3: smac_q[47:32] <= snk_dat_i;
                            3'd4: smac_q[31:16] <= snk_dat_i;
                            3'd5: smac_q[15:0]  <= snk_dat_i;
                            3'd6: begin
                                tagged_q <= (snk_dat_i == c_tpid_8021q);
                                if (snk_dat_i != c_tpid_8021q)
                                    state <= S_ISSUE;
                            end
                            3'd7: begin
                                tci_q <= snk_dat_i;
                                state <= S_ISSUE;
                            end
                            default: ;
                        endcase
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_END;
                end
                S_WAIT_END: begin
                    if (cyc_rise) begin
                        state <= S_HDR;
                        wcnt  <= 3'd0;
                    end else if (!snk_cyc_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rq_valid_o    <= 1'b0;
            rq_dmac_o     <= 48'd0;
            rq_smac_o     <= 48'd0;
            rq_vid_o      <= 12'd0;
            rq_prio_o     <= 3'd0;
            rq_has_prio_o <= 1'b0;
        end else begin
            unique case (1'b1)
                issue_load: begin
                    rq_valid_o    <= 1'b1;
                    rq_dmac_o     <= dmac_q;
                    rq_smac_o     <= smac_q;
                    rq_has_prio_o <= tagged_q;
                    rq_prio_o     <= tagged_q ? tci_q[15:13] : pprio_i;
                    // A zero VID in the tag is a priority-only tag.
                    rq_vid_o      <= (tagged_q && tci_q[11:0] != 12'd0)
                                     ? tci_q[11:0] : pvid_i;
                end
                (rq_valid_o & rq_ack_i): begin
                    rq_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt_o  <= '0;
            abort_cnt_o <= '0;
        end else begin
            if (issue_drop && drop_cnt_o != c_cnt_max)
                drop_cnt_o <= drop_cnt_o + 1'b1;
            if (hdr_abort && abort_cnt_o != c_cnt_max)
                abort_cnt_o <= abort_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_rtu_rq_extractor.sv
// tb_rtu_rq_extractor: vector table, directed corner cases and a
// randomized frame stream checked against a header-parsing model.
module tb_rtu_rq_extractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, cyc, stb, stall, ack;
    logic [1:0]  adr;
    logic [15:0] dat;
    logic [11:0] pvid;
    logic [2:0]  pprio;
    logic        rq_valid, rq_has;
    logic [47:0] rq_dmac, rq_smac;
    logic [11:0] rq_vid;
    logic [2:0]  rq_prio;
    logic [4:0]  rq_port;
    logic [1:0]  drop_cnt, abort_cnt;

    rtu_rq_extractor #(
        .g_port_index(3),
        .g_port_width(5),
        .g_cnt_width (2)
    ) dut (
        .clk_sys_i    (clk),
        .rst_n_i      (rst_n),
        .snk_cyc_i    (cyc),
        .snk_stb_i    (stb),
        .snk_stall_i  (stall),
        .snk_adr_i    (adr),
        .snk_dat_i    (dat),
        .pvid_i       (pvid),
        .pprio_i      (pprio),
        .rq_valid_o   (rq_valid),
        .rq_ack_i     (ack),
        .rq_dmac_o    (rq_dmac),
        .rq_smac_o    (rq_smac),
        .rq_vid_o     (rq_vid),
        .rq_prio_o    (rq_prio),
        .rq_has_prio_o(rq_has),
        .rq_port_o    (rq_port),
        .drop_cnt_o   (drop_cnt),
        .abort_cnt_o  (abort_cnt)
    );

    typedef struct {
        logic [47:0] dmac;
        logic [47:0] smac;
        logic [11:0] vid;
        logic [2:0]  prio;
        logic        has;
        int          edge_n;
    } req_t;

    typedef struct {
        logic [15:0] w6;
        logic [15:0] tci;
        logic [11:0] pvid;
        logic [2:0]  pprio;
        logic [11:0] e_vid;
        logic [2:0]  e_prio;
        logic        e_has;
    } vec_t;

    req_t        got_q[$];
    req_t        last;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          hi_cnt = 0;
    logic        pv = 1'b0;
    logic        pa = 1'b0;
    logic [15:0] fw[0:63];
    int          edge_w[0:63];
    vec_t        vecs[7];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Records every freshly presented request and checks held ones.
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            pv = 1'b0;
            pa = 1'b0;
        end else begin
            if (rq_valid) hi_cnt++;
            if (pv && !pa) begin
                chk("hold.valid", rq_valid, 1);
                chk("hold.dmac", rq_dmac, last.dmac);
                chk("hold.smac", rq_smac, last.smac);
                chk("hold.vid", rq_vid, last.vid);
            end else if (rq_valid) begin
                last.dmac   = rq_dmac;
                last.smac   = rq_smac;
                last.vid    = rq_vid;
                last.prio   = rq_prio;
                last.has    = rq_has;
                last.edge_n = cyc_n;
                got_q.push_back(last);
            end
            pv = rq_valid;
            pa = ack;
        end
    end

    function automatic req_t ref_req(input logic [47:0] d, s,
                                     input logic [15:0] w6, tci,
                                     input logic [11:0] pv_in,
                                     input logic [2:0] pp_in);
        req_t r;
        r.dmac   = d;
        r.smac   = s;
        r.edge_n = 0;
        if (w6 == 16'h8100) begin
            r.has  = 1'b1;
            r.prio = tci[15:13];
            r.vid  = (tci[11:0] == 12'd0) ? pv_in : tci[11:0];
        end else begin
            r.has  = 1'b0;
            r.prio = pp_in;
            r.vid  = pv_in;
        end
        return r;
    endfunction

    task automatic build_frame(input logic [47:0] d, s,
                               input logic [15:0] w6, tci);
        for (int i = 0; i < 64; i++) fw[i] = 16'($urandom);
        fw[0] = d[47:32];
        fw[1] = d[31:16];
        fw[2] = d[15:0];
        fw[3] = s[47:32];
        fw[4] = s[31:16];
        fw[5] = s[15:0];
        fw[6] = w6;
        if (w6 == 16'h8100) fw[7] = tci;
    endtask

    task automatic drive_frame(input int n, input bit stl, input bit oob,
                               input int stop_at);
        int lim;
        lim = (stop_at >= 0) ? stop_at : n;
        cyc = 1'b1;
        stb = 1'b0;
        stall = 1'b0;
        adr = 2'd0;
        @(posedge clk); #1;
        for (int i = 0; i < lim; i++) begin
            if (oob && (i % 3 == 1)) begin
                stb = 1'b1; stall = 1'b0; adr = 2'd1; dat = 16'h8100;
                @(posedge clk); #1;
            end
            if (stl && (i % 2 == 1)) begin
                stb = 1'b1; stall = 1'b1; adr = 2'd0; dat = ~fw[i];
                @(posedge clk); #1;
            end
            stb = 1'b1; stall = 1'b0; adr = 2'd0; dat = fw[i];
            edge_w[i] = cyc_n + 1;
            @(posedge clk); #1;
        end
        stb = 1'b0; stall = 1'b0; adr = 2'd0; dat = 16'd0; cyc = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic expect_req(input string nm, input req_t e,
                              input int e_edge);
        req_t g;
        if (got_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.present: got no request expected one", nm);
        end else begin
            g = got_q.pop_front();
            chk({nm, ".dmac"}, g.dmac, e.dmac);
            chk({nm, ".smac"}, g.smac, e.smac);
            chk({nm, ".vid"}, g.vid, e.vid);
            chk({nm, ".prio"}, g.prio, e.prio);
            chk({nm, ".has"}, g.has, e.has);
            if (e_edge >= 0) chk({nm, ".latency"}, g.edge_n, e_edge);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [47:0] d, s;
        logic [15:0] w6, tci;
        req_t        e, e1;
        int          h0, stop, n, exp_abort, ci;
        bit          tg;

        vecs[0] = '{16'h88f7, 16'h0000, 12'd100, 3'd0, 12'd100, 3'd0, 1'b0};
        vecs[1] = '{16'h8100, 16'hA00A, 12'd100, 3'd2, 12'd10,  3'd5, 1'b1};
        vecs[2] = '{16'h8100, 16'h6000, 12'd7,   3'd1, 12'd7,   3'd3, 1'b1};
        vecs[3] = '{16'h0800, 16'h0000, 12'hfff, 3'd7, 12'hfff, 3'd7, 1'b0};
        vecs[4] = '{16'h8100, 16'h1fff, 12'd5,   3'd0, 12'hfff, 3'd0, 1'b1};
        vecs[5] = '{16'h8100, 16'hE001, 12'd9,   3'd4, 12'd1,   3'd7, 1'b1};
        vecs[6] = '{16'h8101, 16'h0000, 12'd3,   3'd6, 12'd3,   3'd6, 1'b0};

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; stall = 1'b0;
        adr = 2'd0; dat = 16'd0; pvid = 12'd0; pprio = 3'd0; ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.valid", rq_valid, 0);
        chk("reset.dmac", rq_dmac, 0);
        chk("reset.smac", rq_smac, 0);
        chk("reset.vid", rq_vid, 0);
        chk("reset.prio", rq_prio, 0);
        chk("reset.has", rq_has, 0);
        chk("reset.drop", drop_cnt, 0);
        chk("reset.abort", abort_cnt, 0);
        chk("reset.port", rq_port, 3);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Vector table; odd entries add stalls and OOB words.
        d = 48'h0250cafebabe;
        s = 48'h060203040506;
        for (int i = 0; i < 7; i++) begin
            pvid  = vecs[i].pvid;
            pprio = vecs[i].pprio;
            build_frame(d, s, vecs[i].w6, vecs[i].tci);
            h0 = hi_cnt;
            drive_frame(14, (i % 2) == 1, (i % 2) == 1, -1);
            repeat (2) @(posedge clk);
            #1;
            e.dmac = d;
            e.smac = s;
            e.vid  = vecs[i].e_vid;
            e.prio = vecs[i].e_prio;
            e.has  = vecs[i].e_has;
            ci = (vecs[i].w6 == 16'h8100) ? 7 : 6;
            expect_req($sformatf("vec%0d", i), e, edge_w[ci] + 1);
            chk($sformatf("vec%0d.pulse", i), hi_cnt - h0, 1);
        end

        // Pending request with no ack: later frames are dropped.
        ack = 1'b0;
        pvid = 12'd42; pprio = 3'd1;
        build_frame(48'h111122223333, 48'h444455556666, 16'h0800, 16'd0);
        e1 = ref_req(48'h111122223333, 48'h444455556666, 16'h0800, 16'd0,
                     pvid, pprio);
        drive_frame(32, 0, 0, -1);
        for (int k = 0; k < 2; k++) begin
            build_frame(48'haaaa0000bbbb + 48'(k), 48'hcc, 16'h0800, 16'd0);
            drive_frame(32, 0, 0, -1);
        end
        repeat (2) @(posedge clk);
        #1;
        expect_req("drop.first", e1, -1);
        chk("drop.valid", rq_valid, 1);
        chk("drop.dmac", rq_dmac, e1.dmac);
        chk("drop.cnt", drop_cnt, 2);
        chk("drop.abort", abort_cnt, 0);
        for (int k = 0; k < 2; k++) begin
            build_frame(48'hdddd0000eeee, 48'hff, 16'h8100, 16'h2005);
            drive_frame(32, 0, 0, -1);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drop.sat", drop_cnt, 3);
        chk("drop.noreq", got_q.size(), 0);
        ack = 1'b1;
        @(posedge clk);
        #1;
        chk("drop.release", rq_valid, 0);

        // Frame cut short after four data words.
        build_frame(48'h0102030405, 48'h0a0b0c, 16'h0800, 16'd0);
        drive_frame(14, 0, 0, 4);
        repeat (2) @(posedge clk);
        #1;
        chk("abort.cnt", abort_cnt, 1);
        chk("abort.noreq", got_q.size(), 0);
        pvid = 12'd77; pprio = 3'd2;
        build_frame(48'h9abcdef01234, 48'h56789abcdef0, 16'h8100, 16'h4000);
        e = ref_req(48'h9abcdef01234, 48'h56789abcdef0, 16'h8100,
                    16'h4000, pvid, pprio);
        drive_frame(16, 0, 0, -1);
        repeat (2) @(posedge clk);
        #1;
        expect_req("abort.next", e, edge_w[7] + 1);

        // Reset during word 3; remainder of that frame must be ignored.
        build_frame(48'h777777777777, 48'h888888888888, 16'h88f7, 16'd0);
        cyc = 1'b1; stb = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            stb = 1'b1; adr = 2'd0; dat = fw[i];
            @(posedge clk); #1;
        end
        stb = 1'b1; dat = fw[3];
        #2 rst_n = 1'b0;
        #1;
        chk("rst.valid", rq_valid, 0);
        chk("rst.dmac", rq_dmac, 0);
        chk("rst.smac", rq_smac, 0);
        chk("rst.vid", rq_vid, 0);
        chk("rst.has", rq_has, 0);
        chk("rst.drop", drop_cnt, 0);
        chk("rst.abort", abort_cnt, 0);
        chk("rst.port", rq_port, 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 3; i < 16; i++) begin
            stb = 1'b1; dat = fw[i];
            @(posedge clk); #1;
        end
        stb = 1'b0; cyc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.noreq", got_q.size(), 0);
        chk("rst.noabort", abort_cnt, 0);
        pvid = 12'd5; pprio = 3'd6;
        build_frame(48'h0250cafebabe, 48'h060203040506, 16'h88f7, 16'd0);
        e = ref_req(48'h0250cafebabe, 48'h060203040506, 16'h88f7, 16'd0,
                    pvid, pprio);
        drive_frame(14, 0, 0, -1);
        repeat (2) @(posedge clk);
        #1;
        expect_req("rst.next", e, edge_w[6] + 1);

        // Randomized frames against the header model.
        exp_abort = 0;
        for (int f = 0; f < 60; f++) begin
            d     = {16'($urandom), 32'($urandom)};
            s     = {16'($urandom), 32'($urandom)};
            tg    = 1'($urandom);
            tci   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) tci[11:0] = 12'd0;
            w6    = tg ? 16'h8100 : 16'($urandom);
            if (!tg && w6 == 16'h8100) w6 = 16'h0800;
            pvid  = 12'($urandom);
            pprio = 3'($urandom);
            n     = $urandom_range(9, 20);
            stop  = ($urandom_range(0, 5) == 0)
                    ? $urandom_range(0, tg ? 7 : 6) : -1;
            build_frame(d, s, w6, tci);
            e = ref_req(d, s, w6, tci, pvid, pprio);
            drive_frame(n, 1'($urandom), 1'($urandom), stop);
            repeat (2) @(posedge clk);
            #1;
            if (stop >= 0) begin
                exp_abort = (exp_abort == 3) ? 3 : exp_abort + 1;
                chk($sformatf("rnd%0d.noreq", f), got_q.size(), 0);
            end else begin
                expect_req($sformatf("rnd%0d", f), e,
                           edge_w[tg ? 7 : 6] + 1);
            end
            chk($sformatf("rnd%0d.abort", f), abort_cnt, exp_abort);
        end
        chk("rnd.drop", drop_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rtu_rq_extractor.md
Name: rtu_rq_extractor

Overview:
- Passive snooper on one port's pipelined WR fabric (Wishbone) stream between endpoint and switch core.
- Parses the Ethernet header of each frame and issues one RTU lookup request (DMAC, SMAC, VID, priority, port) to the RTU request FIFO over a valid/ack handshake.
- One instance per switch port. It never stalls or modifies the fabric.

Parameters:
- g_port_index, 0, port number reported in every request (0..g_num_ports).
- g_port_width, 5, width of rq_port_o.
- g_cnt_width, 16, width of the drop/abort statistics counters.

Ports:
- clk_sys_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- snk_cyc_i  in  1  observed fabric CYC.
- snk_stb_i  in  1  observed fabric STB.
- snk_stall_i  in  1  observed fabric STALL driven by the sink.
- snk_adr_i  in  2  observed fabric address (0 = data; 1 = OOB; 2 = status; 3 = user).
- snk_dat_i  in  16  observed fabric data, big-endian byte order.
- pvid_i  in  12  port default VID.
- pprio_i  in  3  port default priority.
- rq_valid_o  out  1  request valid.
- rq_ack_i  in  1  request accepted by the RTU.
- rq_dmac_o  out  48  destination MAC.
- rq_smac_o  out  48  source MAC.
- rq_vid_o  out  12  VLAN ID.
- rq_prio_o  out  3  priority.
- rq_has_prio_o  out  1  priority taken from the 802.1Q tag.
- rq_port_o  out  g_port_width  = g_port_index.
- drop_cnt_o  out  g_cnt_width  requests lost because the previous request was still pending.
- abort_cnt_o  out  g_cnt_width  frames ended before the header was complete.

Behaviour:
- Reset values: all outputs 0, except rq_port_o, which is constant g_port_index. FSM in IDLE.
- Accepted word: cyc & stb & !stall. Only accepted words with adr=0 advance the header word counter. Words with adr 1..3 are ignored.
- Frame start: rising edge of snk_cyc_i, detected by a registered cyc.
- FSM states:
  - IDLE: on cyc rise -> HDR, word counter = 0.
  - HDR: capture accepted data words.
    - Words 0–2 -> DMAC[47:32], [31:16], [15:0].
    - Words 3–5 -> SMAC, same order.
    - Word 6 = TPID/ethertype. If it is not 0x8100, header is complete -> ISSUE.
    - If word 6 is 0x8100, word 7 = TCI; header is complete at word 7 -> ISSUE.
    - Cyc falls while in HDR -> abort_cnt_o increments (saturating), no request, -> IDLE.
  - ISSUE (one cycle): if rq_valid_o=0, load the request registers and set rq_valid_o on the next edge. If rq_valid_o=1 and rq_ack_i=0 in this cycle, discard the new request and increment drop_cnt_o (saturating). If rq_ack_i=1 in this cycle, the load wins (valid remains 1 with the new contents). Then -> WAIT_END.
  - WAIT_END: ignore data until cyc falls -> IDLE.
  - Cyc rise while in WAIT_END (back-to-back, no idle cycle): go directly to HDR.
- VID/priority rules:
  - Untagged frame: vid = pvid_i, prio = pprio_i, has_prio = 0.
  - Tagged frame: prio = TCI[15:13], has_prio = 1. vid = TCI[11:0], except TCI[11:0] = 0 (priority tag), which gives vid = pvid_i.
  - pvid_i and pprio_i are sampled in the ISSUE cycle.
- Handshake: rq_valid_o is held with stable contents until a cycle in which rq_ack_i=1, then it drops on the next edge unless reloaded in that same cycle. rq_ack_i is ignored while rq_valid_o=0.
- Latency: rq_valid_o rises 2 clocks after the accepted word that completes the header (word 6 untagged, word 7 tagged).
- Counters saturate at all-ones and do not wrap. They are cleared only by reset.
- Asynchronous reset mid-frame: everything is cleared. Because the registered cyc also resets, a frame still in progress when reset releases (cyc already high) produces no cyc rise, so it is not parsed and not counted.

Test Plan:
- Untagged frame, DMAC 02:50:ca:fe:ba:be, SMAC 06:02:03:04:05:06, ethertype 0x88f7, pvid_i=100, pprio_i=0, rq_ack_i tied 1 -> one request: dmac=0x0250cafebabe, smac=0x060203040506, vid=100, prio=0, has_prio=0, rq_valid_o high 2 clocks after word 6, for exactly 1 cycle.
- Tagged frame with TCI 0xA00A (prio 5, vid 10), plus a second frame with TCI 0x6000 and pvid_i=7 -> vid=10/prio=5/has_prio=1, then vid=7/prio=3/has_prio=1.
- Stall inserted on every other word, plus OOB (adr=1) words interleaved in the header -> requests identical to the unstalled case. No extra words counted.
- rq_ack_i held 0 over three back-to-back 64-byte frames -> first request held stable, drop_cnt_o=2. Raise ack -> rq_valid_o drops after 1 cycle.
- Cyc deasserted after 4 data words -> no request, abort_cnt_o=1. The next full frame produces a correct request.
- rst_n_i asserted during word 3 of a frame -> all outputs 0 immediately. After release, the remainder of that frame produces no request, and the following frame parses correctly.
